// File: rtl/bvshl_eq_checker.sv
// rtl/bvshl_eq_checker.sv - sequential checker for (x << s) == t with satisfiability and step count
module bvshl_eq_checker #(
  parameter int W  = 4,
  parameter int SW = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  in_x,
  input  logic [SW-1:0] in_s,
  input  logic [W-1:0]  in_t,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          out_eq,
  output logic          out_sat,
  output logic [SW:0]   out_steps
);

  typedef enum logic [1:0] {IDLE, SHIFT, CMP, DONE} state_t;

  // Clamping to W only matters when the shift field can actually reach W.
  localparam bit          CLAMP   = (W < (1 << SW));
  localparam logic [SW:0] W_STEPS = CLAMP ? (SW+1)'(W) : '0;
  localparam logic [SW:0] ONE     = (SW+1)'(1);

  state_t        state_q;
  logic [W-1:0]  acc_q;
  logic [W-1:0]  tgt_q;
  logic [W-1:0]  mask_q;
  logic [SW:0]   cnt_q;
  logic [SW:0]   steps_q;
  logic          in_ready_q;
  logic          out_valid_q;
  logic          out_eq_q;
  logic          out_sat_q;
  logic [SW:0]   out_steps_q;

  logic [SW:0]   s_ext;
  logic [SW:0]   cnt_init;

  assign s_ext    = {1'b0, in_s};
  assign cnt_init = (CLAMP && (s_ext >= W_STEPS)) ? W_STEPS : s_ext;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      tgt_q       <= '0;
      mask_q      <= '0;
      cnt_q       <= '0;
      steps_q     <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_eq_q    <= 1'b0;
      out_sat_q   <= 1'b0;
      out_steps_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            acc_q      <= in_x;
            tgt_q      <= in_t;
            mask_q     <= '0;
            cnt_q      <= cnt_init;
            steps_q    <= '0;
            in_ready_q <= 1'b0;
            state_q    <= (cnt_init == '0) ? CMP : SHIFT;
          end
        end
        SHIFT: begin
          // mask tracks the low bits of t that any shifted x must leave zero
          acc_q   <= {acc_q[W-2:0], 1'b0};
          mask_q  <= {mask_q[W-2:0], 1'b1};
          cnt_q   <= cnt_q - ONE;
          steps_q <= steps_q + ONE;
          if (cnt_q == ONE) begin
            state_q <= CMP;
          end
        end
        CMP: begin
          out_eq_q    <= (acc_q == tgt_q);
          out_sat_q   <= ((tgt_q & mask_q) == '0);
          out_steps_q <= steps_q;
          out_valid_q <= 1'b1;
          state_q     <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_eq    = out_eq_q;
  assign out_sat   = out_sat_q;
  assign out_steps = out_steps_q;

endmodule

// File: tb/tb_bvshl_eq_checker.sv
// tb/tb_bvshl_eq_checker.sv - randomized and exhaustive self-checking bench for bvshl_eq_checker
module tb_bvshl_eq_checker;

  localparam int W  = 4;
  localparam int SW = 3;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_x;
  logic [SW-1:0] in_s;
  logic [W-1:0]  in_t;
  logic          out_valid;
  logic          out_ready;
  logic          out_eq;
  logic          out_sat;
  logic [SW:0]   out_steps;

  int checks;
  int errors;

  bvshl_eq_checker #(.W(W), .SW(SW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_x      (in_x),
    .in_s      (in_s),
    .in_t      (in_t),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_eq    (out_eq),
    .out_sat   (out_sat),
    .out_steps (out_steps)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: arithmetic view of the constraint, independent of any shift sequencing.
  function automatic void model(input int x, input int s, input int t,
                                output int eq, output int sat, output int steps);
    int shifted;
    steps   = (s < W) ? s : W;
    shifted = (x << steps) & ((1 << W) - 1);
    eq      = (shifted == t) ? 1 : 0;
    sat     = ((t & ((1 << steps) - 1)) == 0) ? 1 : 0;
  endfunction

  task automatic run_txn(input int x, input int s, input int t, input int hold, input bit clash);
    int e_eq, e_sat, e_steps, n, lat;
    model(x, s, t, e_eq, e_sat, e_steps);
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      chk("idle_timeout", in_ready, 1);
      return;
    end
    in_valid = 1'b1;
    in_x = x[W-1:0];
    in_s = s[SW-1:0];
    in_t = t[W-1:0];
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_x = W'($urandom);
    in_s = SW'($urandom);
    in_t = W'($urandom);
    chk("busy_in_ready", in_ready, 0);
    // latency counts the accept cycle as cycle 1
    lat = 1;
    while (!out_valid && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk("latency", lat, e_steps + 2);
    chk("eq", out_eq, e_eq);
    chk("sat", out_sat, e_sat);
    chk("steps", out_steps, e_steps);
    chk("eq_implies_sat", out_eq & ~out_sat, 0);
    chk("done_in_ready", in_ready, 0);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      chk("hold_valid", out_valid, 1);
      chk("hold_eq", out_eq, e_eq);
      chk("hold_sat", out_sat, e_sat);
      chk("hold_steps", out_steps, e_steps);
      chk("hold_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    if (clash) begin
      in_valid = 1'b1;
      in_x = W'($urandom);
      in_s = SW'($urandom);
      in_t = W'($urandom);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    in_valid  = 1'b0;
    chk("drain_valid", out_valid, 0);
    chk("drain_in_ready", in_ready, 1);
    chk("keep_eq", out_eq, e_eq);
    chk("keep_steps", out_steps, e_steps);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    checks    = 0;
    errors    = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_x      = '0;
    in_s      = '0;
    in_t      = '0;
    out_ready = 1'b0;
    #2;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_eq", out_eq, 0);
    chk("rst_sat", out_sat, 0);
    chk("rst_steps", out_steps, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    run_txn(4'b0011, 1, 4'b0110, 0, 1'b0);
    run_txn(4'b1001, 2, 4'b0100, 0, 1'b0);
    run_txn(4'b0001, 0, 4'b0010, 0, 1'b0);
    run_txn(4'b1111, 6, 4'b0000, 0, 1'b0);
    run_txn(4'b1111, 6, 4'b0001, 0, 1'b0);
    run_txn(4'b0001, 2, 4'b0101, 5, 1'b0);
    run_txn(4'b0011, 1, 4'b0110, 1, 1'b1);
    run_txn(4'b0101, 7, 4'b0000, 0, 1'b0);

    // async reset one step into a shift, then a clean transaction
    @(negedge clk);
    in_valid = 1'b1;
    in_x = 4'b0001;
    in_s = 3'd3;
    in_t = 4'b1000;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_in_ready", in_ready, 1);
    chk("midrst_steps", out_steps, 0);
    @(negedge clk);
    rst = 1'b0;
    run_txn(4'b0011, 1, 4'b0100, 0, 1'b0);
    run_txn(4'b0001, 3, 4'b1000, 0, 1'b0);

    for (int x = 0; x < (1 << W); x++)
      for (int s = 0; s < (1 << SW); s++)
        for (int t = 0; t < (1 << W); t++)
          run_txn(x, s, t, $urandom_range(0, 2), ($urandom_range(0, 3) == 0));

    for (int i = 0; i < 300; i++)
      run_txn($urandom_range(0, (1 << W) - 1), $urandom_range(0, (1 << SW) - 1),
              $urandom_range(0, (1 << W) - 1), $urandom_range(0, 4), $urandom_range(0, 1) == 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
